seq_mult_frac: RTL

Sequential signed fractional multiplier that serves the start/busy handshake issued by each systolic processing element (PE). A PE pulses start with an input word and a coefficient. This block then runs a radix-2 shift-add multiply and returns a rounded, saturated fixed-point product. The returned product feeds the PE's accumulate adder. It is sized to finish well inside the 30-clock per-word slot.

---
 rtl/seq_mult_frac.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seq_mult_frac.sv
// Sequential signed fractional multiplier for the systolic PE start/busy handshake.
// Radix-2 LSB-first shift-add on magnitudes, then round half away from zero and saturate.
module seq_mult_frac #(
    parameter int WORDLENGTH = 16,
    parameter int FRAC_BITS  = 15
) (
    input  logic                  clk30x,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORDLENGTH-1:0] a,
    input  logic [WORDLENGTH-1:0] b,
    output logic [WORDLENGTH-1:0] product,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf
);

    localparam int ACC_W = 2 * WORDLENGTH;
    localparam int CNT_W = (WORDLENGTH > 1) ? $clog2(WORDLENGTH) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(WORDLENGTH - 1);
    localparam logic [ACC_W-1:0]      RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic [ACC_W-1:0]      POS_LIM  = {{(WORDLENGTH + 1){1'b0}}, {(WORDLENGTH - 1){1'b1}}};
    localparam logic [ACC_W-1:0]      NEG_LIM  = ACC_W'(1) << (WORDLENGTH - 1);
    localparam logic [WORDLENGTH-1:0] SAT_POS  = {1'b0, {(WORDLENGTH - 1){1'b1}}};
    localparam logic [WORDLENGTH-1:0] SAT_NEG  = {1'b1, {(WORDLENGTH - 1){1'b0}}};
    localparam logic [WORDLENGTH-1:0] ONE_W    = {{(WORDLENGTH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // |0x8000| stays representable because the magnitude is treated as unsigned.
    function automatic logic [WORDLENGTH-1:0] abs_val(input logic [WORDLENGTH-1:0] v);
        logic [WORDLENGTH-1:0] res;
        if (v[WORDLENGTH-1]) begin
            res = ~v + ONE_W;
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t                state_r, state_s;
    logic                  sign_r, sign_s;
    logic [WORDLENGTH-1:0] ma_r, ma_s;
    logic [WORDLENGTH-1:0] mb_r, mb_s;
    logic [ACC_W-1:0]      acc_r, acc_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [WORDLENGTH-1:0] product_r, product_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  ovf_r, ovf_s;

    logic [ACC_W-1:0]      partial_s;
    logic [ACC_W-1:0]      rnd_s;
    logic [ACC_W-1:0]      mag_s;

    assign partial_s = {{WORDLENGTH{1'b0}}, ma_r} << cnt_r;
    assign rnd_s     = acc_r + RND_HALF;
    assign mag_s     = rnd_s >> FRAC_BITS;

    // Next-state and datapath update for IDLE -> MUL -> FIN.
    always_comb begin
        state_s   = state_r;
        sign_s    = sign_r;
        ma_s      = ma_r;
        mb_s      = mb_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        product_s = product_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        ovf_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = MUL;
                    sign_s  = a[WORDLENGTH-1] ^ b[WORDLENGTH-1];
                    ma_s    = abs_val(a);
                    mb_s    = abs_val(b);
                    acc_s   = {ACC_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            MUL: begin
                if (mb_r[cnt_r]) begin
                    acc_s = acc_r + partial_s;
                end else begin
                    acc_s = acc_r;
                end
                cnt_s = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    state_s = FIN;
                end else begin
                    state_s = MUL;
                end
            end
            FIN: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b1;
                // Negative side allows one extra LSB of magnitude (min negative).
                if (!sign_r) begin
                    if (mag_s > POS_LIM) begin
                        product_s = SAT_POS;
                        ovf_s     = 1'b1;
                    end else begin
                        product_s = mag_s[WORDLENGTH-1:0];
                    end
                end else begin
                    if (mag_s > NEG_LIM) begin
                        product_s = SAT_NEG;
                        ovf_s     = 1'b1;
                    end else begin
                        product_s = ~mag_s[WORDLENGTH-1:0] + ONE_W;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk30x or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            sign_r    <= 1'b0;
            ma_r      <= {WORDLENGTH{1'b0}};
            mb_r      <= {WORDLENGTH{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            product_r <= {WORDLENGTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            sign_r    <= sign_s;
            ma_r      <= ma_s;
            mb_r      <= mb_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            ovf_r     <= ovf_s;
        end
    end

    assign product = product_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign ovf     = ovf_r;

endmodule
